// File: rtl/knn_attr_vec_pio.sv
// Multi-channel attribute PIO: per-channel shadow registers, an atomic COMMIT
// into a show-ahead vector FIFO, and a valid/ready stream to the KNN engine.
module knn_attr_vec_pio #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     irq
);

  localparam int VEC_W = NUM_CH * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [VEC_W-1:0]  mem_q    [DEPTH];
  logic [VEC_W-1:0]  shadow_vec;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              irq_en_q, irq_en_d;
  logic              overflow_q, overflow_d;
  logic              drained_q, drained_d;
  logic              irq_q;

  logic wr, ctrl_wr, stat_wr;
  logic commit, flush, empty, full, pop, push, ovf_set, drn_set;
  logic unused_wdata;

  assign unused_wdata = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == ADDR_W'(NUM_CH));
  assign stat_wr = wr && (address == ADDR_W'(NUM_CH + 1));
  assign commit  = ctrl_wr & writedata[0];
  assign flush   = ctrl_wr & writedata[1];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // FLUSH overrides both sides of the FIFO; a pop frees the slot a full push needs
  assign pop     = ~empty & out_ready & ~flush;
  assign push    = commit & ~flush & (~full | pop);
  assign ovf_set = commit & ~flush & full & ~pop;
  assign drn_set = pop & (count_q == CNT_W'(1)) & ~push;

  always_comb begin
    shadow_vec = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      shadow_vec[k*DATA_W +: DATA_W] = shadow_q[k];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins
  always_comb begin
    irq_en_d   = ctrl_wr ? writedata[2] : irq_en_q;
    overflow_d = (stat_wr & writedata[2]) ? 1'b0 : overflow_q;
    drained_d  = (stat_wr & writedata[3]) ? 1'b0 : drained_q;
    if (ovf_set) overflow_d = 1'b1;
    if (drn_set) drained_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)  mem_q[i]    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (wr && (address == ADDR_W'(k))) shadow_q[k] <= writedata[DATA_W-1:0];
      end
      if (push) mem_q[wr_ptr_q] <= shadow_vec;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      overflow_q <= overflow_d;
      drained_q  <= drained_d;
      irq_q      <= irq_en_q & drained_q;
    end
  end

  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign irq       = irq_q;

  always_comb begin
    readdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (address == ADDR_W'(k)) readdata = 32'(shadow_q[k]);
    end
    if (address == ADDR_W'(NUM_CH)) readdata[2] = irq_en_q;
    if (address == ADDR_W'(NUM_CH + 1)) begin
      readdata = {8'h00, 8'(count_q), 12'h000, drained_q, overflow_q, full, empty};
    end
  end

endmodule
